rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Shares the single register-file write port among several writeback requesters (ALU, load unit, multiply/divide unit). Each cycle it grants at most one requester via a valid/ready handshake and registers the winning address/data. Its `wr_en`/`wr_addr` outputs drive the enable and select of the register-file write decoder (5-to-32); `wr_data` drives the register-file data bus.

## Interface
- `NUM_REQ`, 3: number of requesters, 2..4
- `DATA_WIDTH`, 32: write data width
- `ADDR_WIDTH`, 5: register index width
- `MAX_WAIT`, 4: wait cycles before a requester is promoted; only used with `RF_ARB_AGING_EN`
- `clock`  in  1  single clock, rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `hold`  in  1  freeze arbitration; no grants while high
- `req_valid`  in  NUM_REQ  per-requester write request
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  flattened destination register index; requester i uses bits [i*5 +: 5]
- `req_data`  in  NUM_REQ*DATA_WIDTH  flattened write data
- `req_ready`  out  NUM_REQ  one-hot grant, combinational, this cycle
- `wr_en`  out  1  registered write enable to decoder
- `wr_addr`  out  ADDR_WIDTH  registered write index
- `wr_data`  out  DATA_WIDTH  registered write data
- `wr_src`  out  2  registered index of the granted requester, for debug

## Operation
- Transfer occurs on requester i when `req_valid[i] && req_ready[i]` at the rising edge.
- Requesters hold `req_valid`, `req_addr` and `req_data` stable until accepted. The arbiter never withdraws a grant that is still being requested.
- `req_ready` is all-zero when `hold=1` or no valid requests exist. Otherwise it is exactly one-hot.
- Base policy is fixed priority: lowest index wins (0 > 1 > 2).
- Writes to register 0 follow the MIPS `$zero` rule:
  - the request is granted and consumed normally;
  - `wr_en` stays 0 for that cycle;
  - `wr_addr`, `wr_data` and `wr_src` still update.
- Output register, each cycle:
  - if a transfer occurs: `wr_en <= (addr != 0)`, `wr_addr/wr_data/wr_src <=` granted values;
  - otherwise: `wr_en <= 0`, and the other outputs hold their values.
- Register file always accepts. There is no backpressure from the write side.
- Reset values: `wr_en=0`, `wr_addr=0`, `wr_data=0`, `wr_src=0`, all wait counters 0. Reset overrides `hold` and every request.
- Reset mid-operation: any request outstanding at the reset edge is not written. Requesters must re-present it after `reset_n` returns high.

## Timing
- Grant is combinational, in the same cycle as the request.
- `wr_en`/`wr_addr`/`wr_data` appear 1 cycle after the transfer edge and are valid for exactly 1 cycle.
- Throughput: one write per cycle.
- With fixed priority and requester 0 valid every cycle, requester 1 is never granted. Aging exists to prevent this.
- `hold` takes effect in the same cycle: `req_ready=0`. `wr_en` is 0 on the following cycle.

## Configuration
- `RF_ARB_AGING_EN` defined:
  - each requester has a saturating wait counter (width clog2(MAX_WAIT)+1);
  - the counter increments when `req_valid[i] && !req_ready[i] && !hold`;
  - it holds during `hold`, and clears on grant or when `req_valid[i]=0`;
  - any requester whose counter is >= `MAX_WAIT` is "starved";
  - if any requester is starved, the lowest-index starved requester wins; otherwise fixed priority applies.
- `RF_ARB_AGING_EN` undefined:
  - no counters; pure fixed priority;
  - `MAX_WAIT` is ignored.

## Structure
- Shared package `rf_arb_pkg`:
  - `REG_ZERO` = 5'd0;
  - default `ADDR_WIDTH`/`DATA_WIDTH` constants;
  - requester index constants `REQ_ALU=0`, `REQ_LOAD=1`, `REQ_MULDIV=2`.
- One sub-module, `rf_arb_age_counter`: a per-requester saturating wait counter with `starved` output. It is instantiated `NUM_REQ` times, only under `RF_ARB_AGING_EN`.
- The top-level holds the priority select, the handshake and the output register.

## Test plan
- Reset: hold `reset_n=0` 2 cycles with `req_valid=3'b111`. Required: `req_ready=0`, `wr_en=0`, `wr_addr=0`, `wr_data=0`.
- Single request: req1 valid, addr=5'd9, data=32'hDEADBEEF. Required: `req_ready=3'b010` that cycle; next cycle `wr_en=1`, `wr_addr=9`, `wr_data=DEADBEEF`, `wr_src=1`.
- Simultaneous requests: req0 (addr 3) and req2 (addr 7) both valid. Required:
  - cycle 0: req0 granted;
  - cycle 1: req2 granted;
  - `wr_addr` sequence 3, then 7, on consecutive cycles.
- `$zero` drop: req0 valid, addr=0, data=32'h1. Required: `req_ready[0]=1`; next cycle `wr_en=0`, `wr_src=0`.
- Hold: `hold=1` for 3 cycles with req1 valid. Required: `req_ready=0` and `wr_en=0` throughout; req1 granted in the first cycle after `hold` drops.
- Aging (`RF_ARB_AGING_EN`, `MAX_WAIT=4`): req0 valid continuously with new data, req1 valid. Required: req1 granted on its 5th cycle of waiting (after 4 denied cycles). Without the macro, req1 is never granted over 20 cycles.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared constants for the register-file write-port arbiter.
package rf_arb_pkg;

  localparam int unsigned RF_ADDR_WIDTH = 5;
  localparam int unsigned RF_DATA_WIDTH = 32;

  // Hard-wired zero register; writes to it are consumed but never enabled.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Requester slots, in fixed-priority order.
  localparam int unsigned REQ_ALU    = 0;
  localparam int unsigned REQ_LOAD   = 1;
  localparam int unsigned REQ_MULDIV = 2;

endpackage : rf_arb_pkg

// File: rtl/rf_arb_age_counter.sv
// Per-requester saturating wait counter; flags the requester as starved once
// it has been denied MAX_WAIT arbitration cycles in a row.
module rf_arb_age_counter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic hold,
  input  logic valid,
  input  logic ready,
  output logic starved
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT) + 1;

  logic [CNT_W-1:0] cnt;

  // Count denied cycles; clear on grant or idle, freeze while held.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!valid || ready) begin
      cnt <= '0;
    end else if (!hold && (cnt < CNT_W'(MAX_WAIT))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign starved = (cnt >= CNT_W'(MAX_WAIT));

endmodule : rf_arb_age_counter

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: fixed-priority (lowest index wins) grant
// of one writeback requester per cycle, registered write outputs, and $zero
// write suppression. Define RF_ARB_AGING_EN to add per-requester wait
// counters that promote a requester denied for MAX_WAIT cycles.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            hold,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            wr_en,
  output logic [ADDR_WIDTH-1:0]           wr_addr,
  output logic [DATA_WIDTH-1:0]           wr_data,
  output logic [1:0]                      wr_src
);

  // Reject configurations the 2-bit source index or counters cannot express.
  if (NUM_REQ < 2 || NUM_REQ > 4 || MAX_WAIT < 1) begin : g_bad_param
    $error("rf_write_arbiter: NUM_REQ must be 2..4 and MAX_WAIT >= 1");
  end

  logic [NUM_REQ-1:0]    starved;
  logic [NUM_REQ-1:0]    starved_valid;
  logic                  found;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [1:0]            sel_src;

`ifdef RF_ARB_AGING_EN
  // One wait counter per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_age
    rf_arb_age_counter #(
      .MAX_WAIT (MAX_WAIT)
    ) u_age (
      .clock   (clock),
      .reset_n (reset_n),
      .hold    (hold),
      .valid   (req_valid[g]),
      .ready   (req_ready[g]),
      .starved (starved[g])
    );
  end
`else
  assign starved = '0;
`endif

  // Grant select: lowest starved requester if any, else lowest valid one.
  always_comb begin
    req_ready     = '0;
    found         = 1'b0;
    starved_valid = starved & req_valid;
    if (reset_n && !hold) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && ((|starved_valid) ? starved_valid[i] : req_valid[i])) begin
          req_ready[i] = 1'b1;
          found        = 1'b1;
        end
      end
    end
  end

  // Mux the granted requester's payload.
  always_comb begin
    xfer     = |req_ready;
    sel_addr = '0;
    sel_data = '0;
    sel_src  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_src  = 2'(i);
      end
    end
  end

  // Write-port register: one-cycle enable pulse, payload held between writes.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_src  <= '0;
    end else begin
      wr_en <= xfer && (sel_addr != ADDR_WIDTH'(REG_ZERO));
      if (xfer) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
        wr_src  <= sel_src;
      end
    end
  end

endmodule : rf_write_arbiter

// File: tb/tb_rf_write_arbiter.sv
// Directed testbench for rf_write_arbiter (default 3 requesters, 5/32-bit).
// Aging expectations follow RF_ARB_AGING_EN when the bench is built with it.
module tb_rf_write_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        hold;
  logic [2:0]  req_valid;
  logic [4:0]  addr [3];
  logic [31:0] data [3];
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  wr_src;

  int vectors = 0;
  int miscompares = 0;
  int grant_cyc;

  assign req_addr = {addr[2], addr[1], addr[0]};
  assign req_data = {data[2], data[1], data[0]};

  always #5 clock = ~clock;

  rf_write_arbiter #(
    .NUM_REQ    (3),
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .MAX_WAIT   (4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .hold      (hold),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_src    (wr_src)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    hold      = 1'b0;
    req_valid = 3'b111;
    for (int i = 0; i < 3; i++) begin
      addr[i] = 5'(i + 1);
      data[i] = 32'hA000_0000 + 32'(i);
    end

    // Reset with all requesters valid.
    step();
    step();
    check_eq("rst_ready", 64'(req_ready), 64'h0);
    check_eq("rst_wr_en", 64'(wr_en), 64'h0);
    check_eq("rst_wr_addr", 64'(wr_addr), 64'h0);
    check_eq("rst_wr_data", 64'(wr_data), 64'h0);
    check_eq("rst_wr_src", 64'(wr_src), 64'h0);

    reset_n   = 1'b1;
    req_valid = 3'b000;
    step();
    check_eq("idle_wr_en", 64'(wr_en), 64'h0);

    // Single request on requester 1.
    req_valid = 3'b010;
    addr[1]   = 5'd9;
    data[1]   = 32'hDEADBEEF;
    #1;
    check_eq("single_ready", 64'(req_ready), 64'b010);
    step();
    req_valid = 3'b000;
    check_eq("single_wr_en", 64'(wr_en), 64'h1);
    check_eq("single_wr_addr", 64'(wr_addr), 64'd9);
    check_eq("single_wr_data", 64'(wr_data), 64'hDEADBEEF);
    check_eq("single_wr_src", 64'(wr_src), 64'd1);
    step();
    check_eq("single_pulse_end", 64'(wr_en), 64'h0);
    check_eq("single_addr_hold", 64'(wr_addr), 64'd9);

    // Requesters 0 and 2 together: 0 first, then 2.
    req_valid = 3'b101;
    addr[0]   = 5'd3;
    data[0]   = 32'h0000_0A0A;
    addr[2]   = 5'd7;
    data[2]   = 32'h0000_0C0C;
    #1;
    check_eq("simul_ready_c0", 64'(req_ready), 64'b001);
    step();
    req_valid = 3'b100;
    check_eq("simul_addr_c0", 64'(wr_addr), 64'd3);
    check_eq("simul_src_c0", 64'(wr_src), 64'd0);
    check_eq("simul_en_c0", 64'(wr_en), 64'h1);
    #1;
    check_eq("simul_ready_c1", 64'(req_ready), 64'b100);
    step();
    req_valid = 3'b000;
    check_eq("simul_addr_c1", 64'(wr_addr), 64'd7);
    check_eq("simul_data_c1", 64'(wr_data), 64'h0C0C);
    check_eq("simul_src_c1", 64'(wr_src), 64'd2);

    // Write to $zero: granted, consumed, no enable.
    req_valid = 3'b001;
    addr[0]   = 5'd0;
    data[0]   = 32'h1;
    #1;
    check_eq("zero_ready", 64'(req_ready), 64'b001);
    step();
    req_valid = 3'b000;
    check_eq("zero_wr_en", 64'(wr_en), 64'h0);
    check_eq("zero_wr_src", 64'(wr_src), 64'd0);
    check_eq("zero_wr_addr", 64'(wr_addr), 64'd0);
    check_eq("zero_wr_data", 64'(wr_data), 64'h1);

    // Hold for three cycles with requester 1 pending.
    hold      = 1'b1;
    req_valid = 3'b010;
    addr[1]   = 5'd12;
    data[1]   = 32'h55;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq($sformatf("hold_ready_%0d", c), 64'(req_ready), 64'h0);
      step();
      check_eq($sformatf("hold_wr_en_%0d", c), 64'(wr_en), 64'h0);
    end
    hold = 1'b0;
    #1;
    check_eq("hold_release_ready", 64'(req_ready), 64'b010);
    step();
    req_valid = 3'b000;
    check_eq("hold_release_en", 64'(wr_en), 64'h1);
    check_eq("hold_release_addr", 64'(wr_addr), 64'd12);

    // Reset mid-operation drops the outstanding request.
    req_valid = 3'b010;
    addr[1]   = 5'd14;
    reset_n   = 1'b0;
    #1;
    check_eq("midrst_ready", 64'(req_ready), 64'h0);
    step();
    check_eq("midrst_wr_en", 64'(wr_en), 64'h0);
    check_eq("midrst_wr_addr", 64'(wr_addr), 64'h0);
    reset_n   = 1'b1;
    req_valid = 3'b000;
    step();

    // Starvation: requester 0 streams new data, requester 1 waits.
    grant_cyc = 0;
    req_valid = 3'b011;
    addr[0]   = 5'd1;
    addr[1]   = 5'd20;
    data[1]   = 32'h111;
    for (int c = 1; c <= 20; c++) begin
      data[0] = 32'(c);
      #1;
      if (req_ready[1] && grant_cyc == 0) grant_cyc = c;
      step();
      if (grant_cyc == c) req_valid[1] = 1'b0;
    end
    req_valid = 3'b000;
`ifdef RF_ARB_AGING_EN
    check_eq("aging_grant_cycle", 64'(grant_cyc), 64'd5);
`else
    check_eq("fixed_prio_starve", 64'(grant_cyc), 64'd0);
`endif
    step();
    check_eq("final_idle_en", 64'(wr_en), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_rf_write_arbiter
